// File: rtl/tim_pkg.sv
// Shared definitions for the timer slave-mode controller.
// - sms_e: slave-mode codes as they appear on sms_i.
// - state_e: sequencing FSM states.
// - SYNC_STAGES_DEF: default depth of the trigger synchronizer.
// - decode_sms: maps a raw sms_i code to its behaviour. Reserved codes behave as disabled.
package tim_pkg;

  typedef enum logic [2:0] {
    SMS_DIS     = 3'b000,
    SMS_RESET   = 3'b100,
    SMS_GATED   = 3'b101,
    SMS_TRIGGER = 3'b110
  } sms_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GATED = 2'd2
  } state_e;

  localparam int SYNC_STAGES_DEF = 2;

  function automatic sms_e decode_sms(input logic [2:0] code);
    case (code)
      3'b100:  return SMS_RESET;
      3'b101:  return SMS_GATED;
      3'b110:  return SMS_TRIGGER;
      default: return SMS_DIS;
    endcase
  endfunction

endpackage

// File: rtl/tim_trg_sync.sv
// Trigger conditioning for the timer slave-mode controller.
// The asynchronous trigger is synchronized, polarity-adjusted, and edge-detected.
// Ports:
//   clk_i      - timer kernel clock
//   aresetn_i  - asynchronous active-low reset
//   i_trg      - raw external trigger (asynchronous)
//   i_tp       - polarity select (1 inverts the trigger)
//   o_trg_lvl  - synchronized, polarity-adjusted trigger level
//   o_trg_edge - one-cycle pulse on a rising edge of o_trg_lvl;
//                it occurs SYNC_STAGES+1 cycles after i_trg
// SYNC_STAGES must be at least 2.
module tim_trg_sync #(
  parameter int SYNC_STAGES = tim_pkg::SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic aresetn_i,
  input  logic i_trg,
  input  logic i_tp,
  output logic o_trg_lvl,
  output logic o_trg_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lvl_d;
  logic                   r_edge;
  logic                   w_lvl;

  // Polarity is applied before edge detection.
  // A tp change can therefore produce an edge by itself.
  assign w_lvl = r_sync[SYNC_STAGES-1] ^ i_tp;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_sync  <= '0;
      r_lvl_d <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_trg};
      r_lvl_d <= w_lvl;
      r_edge  <= w_lvl & ~r_lvl_d;
    end
  end

  assign o_trg_lvl  = w_lvl;
  assign o_trg_edge = r_edge;

endmodule

// File: rtl/tim_slave_mode_ctrl.sv
// Slave-mode and sequencing controller for the timer time base.
// It generates the counter enable and the reinit (ug) pulse from software control and an external trigger.
// Supported behaviour: disabled, reset, gated and trigger slave modes; one-pulse mode; and a repetition counter that qualifies update events.
// Ports:
//   clk_i, aresetn_i - kernel clock, asynchronous active-low reset
//   cen_sw_i         - software counter enable (CR1.CEN)
//   opm_i            - one-pulse mode
//   sms_i            - slave mode select
//   tp_i, trg_i      - trigger polarity and raw trigger
//   uev_i            - raw update event from the time base
//   rep_i            - repetition reload value
//   cen_o, ug_o      - counter enable and reinit pulse to the time base
//   uev_o            - qualified update event
//   tif_o            - trigger flag pulse
//   cen_set_o        - hardware set of CR1.CEN (trigger start)
//   cen_clr_o        - hardware clear of CR1.CEN (one-pulse stop)
module tim_slave_mode_ctrl
  import tim_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int REP_WIDTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 aresetn_i,
  input  logic                 cen_sw_i,
  input  logic                 opm_i,
  input  logic [2:0]           sms_i,
  input  logic                 tp_i,
  input  logic                 trg_i,
  input  logic                 uev_i,
  input  logic [REP_WIDTH-1:0] rep_i,
  output logic                 cen_o,
  output logic                 ug_o,
  output logic                 uev_o,
  output logic                 tif_o,
  output logic                 cen_set_o,
  output logic                 cen_clr_o
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [2:0]           r_sms_prev;
  logic [REP_WIDTH-1:0] r_rep_cnt;
  logic                 r_cen, r_ug, r_tif, r_uev, r_clr;
  logic                 w_trg_lvl, w_trg_edge;
  logic                 w_sms_chg, w_ug_req, w_uev_q, w_cen_set, w_cen_nxt;
  sms_e                 w_mode;

  tim_trg_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trg_sync (
    .clk_i      (clk_i),
    .aresetn_i  (aresetn_i),
    .i_trg      (trg_i),
    .i_tp       (tp_i),
    .o_trg_lvl  (w_trg_lvl),
    .o_trg_edge (w_trg_edge)
  );

  assign w_mode    = decode_sms(sms_i);
  assign w_sms_chg = (sms_i != r_sms_prev);
  // A reset-mode trigger takes precedence over a coincident update event.
  // That update event is swallowed by the reload.
  assign w_ug_req  = w_trg_edge & (w_mode == SMS_RESET);
  assign w_uev_q   = uev_i & (r_rep_cnt == '0) & ~w_ug_req;

  always_comb begin
    w_state_nxt = r_state;
    w_cen_set   = 1'b0;
    if (w_sms_chg) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          case (w_mode)
            SMS_TRIGGER: begin
              if (w_trg_edge) begin
                w_state_nxt = ST_RUN;
                w_cen_set   = 1'b1;
              end
            end
            SMS_GATED: w_state_nxt = ST_GATED;
            default:   if (cen_sw_i) w_state_nxt = ST_RUN;
          endcase
        end
        ST_RUN: begin
          if ((w_uev_q && opm_i) || !cen_sw_i) w_state_nxt = ST_IDLE;
        end
        ST_GATED: w_state_nxt = ST_GATED;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
    // The gate is not qualified by an OPM stop.
    // In gated mode, software clears CEN in response to cen_clr_o.
    w_cen_nxt = (w_state_nxt == ST_RUN) ||
                ((w_state_nxt == ST_GATED) && cen_sw_i && w_trg_lvl);
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state    <= ST_IDLE;
      r_sms_prev <= 3'b000;
      r_cen      <= 1'b0;
      r_ug       <= 1'b0;
      r_tif      <= 1'b0;
      r_uev      <= 1'b0;
      r_clr      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sms_prev <= sms_i;
      r_cen      <= w_cen_nxt;
      r_ug       <= w_ug_req;
      r_tif      <= w_trg_edge & (w_mode != SMS_DIS);
      r_uev      <= w_uev_q;
      r_clr      <= w_uev_q & opm_i;
    end
  end

  // The counter reloads on the reinit request and again while ug_o is high.
  // It therefore restarts from rep_i when the time base is reinitialised.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_rep_cnt <= '0;
    end else if (w_ug_req || r_ug || (uev_i && (r_rep_cnt == '0))) begin
      r_rep_cnt <= rep_i;
    end else if (uev_i) begin
      r_rep_cnt <= r_rep_cnt - REP_WIDTH'(1);
    end
  end

  assign cen_o     = r_cen;
  assign ug_o      = r_ug;
  assign uev_o     = r_uev;
  assign tif_o     = r_tif;
  assign cen_set_o = w_cen_set;
  assign cen_clr_o = r_clr;

endmodule
